ro_trng_sampler: RTL

Parametrised multi-ring-oscillator entropy source. NUM_RO free-running rings of RO_STAGES inverters are XOR-combined and sampled on CLK. The raw bit is synchronised, health-checked with a repetition-count test, optionally von Neumann debiased, and assembled into WORD_W-bit words. Words leave on a valid/ready handshake. The block supersedes the single fixed ring oscillator as the TRNG front end. A TEST_MODE input replaces the rings with a deterministic bit stream for verification and bring-up.

---
 rtl/ro_trng_sampler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ro_trng_sampler.sv
// Multi-ring-oscillator entropy source: XORed rings, two-flop sampler, repetition-count
// health test, optional von Neumann debiasing and MSB-first word assembly with valid/ready.
module ro_trng_sampler #(
    parameter int unsigned NUM_RO    = 8,
    parameter int unsigned RO_STAGES = 3,
    parameter int unsigned WORD_W    = 32,
    parameter bit          DEBIAS    = 1'b1,
    parameter int unsigned REP_LIMIT = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic              TEST_MODE,
    input  logic              TEST_BIT,
    output logic [WORD_W-1:0] DATA_O,
    output logic              VALID_O,
    input  logic              READY_I,
    output logic              HEALTH_FAIL_O
);
    localparam int unsigned RUN_W = $clog2(REP_LIMIT + 1);
    localparam int unsigned CNT_W = $clog2(WORD_W);
    localparam int unsigned SH_W  = WORD_W - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FAIL} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ring_en;
    logic [NUM_RO-1:0] ring_out;
    logic              raw;
    logic              s1;
    logic              s2;
    logic              v1;
    logic              v2;
    logic              last_bit;
    logic              phase;
    logic              pair_a;
    logic [RUN_W-1:0]  run_cnt;
    logic [RUN_W-1:0]  run_nxt;
    logic [SH_W-1:0]   shifter;
    logic [CNT_W-1:0]  bit_cnt;
    logic              proc_c;
    logic              clear_c;
    logic              flush_c;
    logic              trip_c;
    logic              emit_c;
    logic              emit_bit_c;

    // Each ring is a gated NAND plus inverters; disabled rings settle to a static level.
    assign ring_en = EN & ~TEST_MODE & ~RESET;
    for (genvar r = 0; r < NUM_RO; r++) begin : g_ring
        logic [RO_STAGES-1:0] node;
        assign node[0] = ~(node[RO_STAGES-1] & ring_en);
        for (genvar s = 1; s < RO_STAGES; s++) begin : g_stage
            assign node[s] = ~node[s-1];
        end
        assign ring_out[r] = node[RO_STAGES-1];
    end

    assign raw = TEST_MODE ? TEST_BIT : ^ring_out;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (EN) state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (trip_c)   state_nxt = ST_FAIL;
                else if (!EN) state_nxt = ST_IDLE;
            end
            ST_FAIL:    state_nxt = ST_FAIL;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // v2 marks that s2 was captured while EN was high, aligning the first processed sample.
    always_comb begin
        proc_c  = 1'b0;
        clear_c = 1'b0;
        case (state)
            ST_IDLE:    clear_c = 1'b1;
            ST_COLLECT: begin
                proc_c  = EN & v2;
                clear_c = ~EN;
            end
            default:    ;
        endcase
    end

    assign flush_c = (state_nxt == ST_FAIL);

    // Health run length and debias pairing for the sample in s2.
    always_comb begin
        run_nxt    = run_cnt;
        trip_c     = 1'b0;
        emit_c     = 1'b0;
        emit_bit_c = s2;
        if (proc_c) begin
            if (run_cnt == '0 || s2 != last_bit)
                run_nxt = RUN_W'(1);
            else if (run_cnt != RUN_W'(REP_LIMIT))
                run_nxt = run_cnt + RUN_W'(1);
            trip_c = (run_nxt == RUN_W'(REP_LIMIT));
            if (DEBIAS) begin
                emit_c     = phase & (pair_a != s2);
                emit_bit_c = pair_a;
            end else begin
                emit_c = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            last_bit      <= 1'b0;
            phase         <= 1'b0;
            pair_a        <= 1'b0;
            run_cnt       <= '0;
            shifter       <= '0;
            bit_cnt       <= '0;
            DATA_O        <= '0;
            VALID_O       <= 1'b0;
            HEALTH_FAIL_O <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            v1 <= EN;
            v2 <= v1;
            if (flush_c) begin
                HEALTH_FAIL_O <= 1'b1;
                DATA_O        <= '0;
                VALID_O       <= 1'b0;
                shifter       <= '0;
                bit_cnt       <= '0;
                phase         <= 1'b0;
                run_cnt       <= run_nxt;
            end else begin
                if (VALID_O && READY_I) VALID_O <= 1'b0;
                if (clear_c) begin
                    run_cnt <= '0;
                    phase   <= 1'b0;
                    shifter <= '0;
                    bit_cnt <= '0;
                end else if (proc_c) begin
                    run_cnt  <= run_nxt;
                    last_bit <= s2;
                    if (DEBIAS) begin
                        phase <= ~phase;
                        if (!phase) pair_a <= s2;
                    end
                    // A completing bit is dropped while a held word is not being read.
                    if (emit_c) begin
                        if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                            if (!VALID_O || READY_I) begin
                                DATA_O  <= {shifter, emit_bit_c};
                                VALID_O <= 1'b1;
                                shifter <= '0;
                                bit_cnt <= '0;
                            end
                        end else begin
                            shifter <= SH_W'({shifter, emit_bit_c});
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule
